// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-level round-robin arbiter that shares one UART TX
// FIFO write port among NUM_REQ byte-stream requesters. Each grant carries a
// whole packet, optionally preceded by a source-identifying header byte, and
// ends on the last byte, on a length cap, or on a stall timeout.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter bit HEADER_EN      = 1'b1,
   parameter int MAX_PKT_LEN    = 64,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int GW            = $clog2(NUM_REQ),
   localparam int SW            = $clog2(TIMEOUT_CYCLES)
) (
   input  logic                 Clk,
   input  logic                 Resetn,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           uart_tx_data,
   output logic                 uart_wr_en,
   input  logic                 uart_full,
   output logic [GW-1:0]        grant_id,
   output logic                 busy,
   output logic                 trunc_pulse,
   output logic                 abort_pulse
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HEADER,
      S_DATA
   } state_t;

   localparam logic [7:0]    HDR_BASE   = 8'hA0;
   // Byte count value that, once reached by a transfer, hits the length cap.
   localparam logic [7:0]    LEN_LAST   = 8'(MAX_PKT_LEN - 1);
   // Stall count value at which a further idle cycle revokes the grant.
   localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
   localparam logic [GW-1:0] RR_RESET   = GW'(NUM_REQ - 1);

   state_t        state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;
   logic [GW-1:0] rr_last_q, rr_last_d;
   logic [7:0]    byte_cnt_q, byte_cnt_d;
   logic [SW-1:0] stall_cnt_q, stall_cnt_d;
   logic          trunc_q, trunc_d;
   logic          abort_q, abort_d;

   logic          win_found;
   logic [GW-1:0] win_idx;
   logic          xfer;

   // Round-robin search: first valid requester after rr_last, wrapping.
   always_comb begin : p_rr_search
      int cand;
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = int'(rr_last_q) + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = GW'(cand);
         end
      end
   end

   // Next-state and output decode; payload path is combinational (zero latency).
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      rr_last_d    = rr_last_q;
      byte_cnt_d   = byte_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      trunc_d      = 1'b0;
      abort_d      = 1'b0;
      req_ready    = '0;
      uart_wr_en   = 1'b0;
      uart_tx_data = 8'h00;
      xfer         = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d = win_idx;
               state_d = HEADER_EN ? S_HEADER : S_DATA;
            end
         end

         S_HEADER: begin
            // The header waits for FIFO space indefinitely; no timeout here.
            uart_tx_data = HDR_BASE | 8'(grant_q);
            uart_wr_en   = !uart_full;
            if (!uart_full) begin
               state_d = S_DATA;
            end
         end

         S_DATA: begin
            req_ready[grant_q] = !uart_full;
            uart_tx_data       = req_data[8*grant_q +: 8];
            xfer               = req_valid[grant_q] & !uart_full;
            uart_wr_en         = xfer;
            if (xfer) begin
               byte_cnt_d  = byte_cnt_q + 8'd1;
               stall_cnt_d = '0;
               if (req_last[grant_q]) begin
                  // Normal end; also wins when last coincides with the cap.
                  state_d     = S_IDLE;
                  rr_last_d   = grant_q;
                  byte_cnt_d  = '0;
               end else if (byte_cnt_q == LEN_LAST) begin
                  state_d     = S_IDLE;
                  rr_last_d   = grant_q;
                  byte_cnt_d  = '0;
                  trunc_d     = 1'b1;
               end
            end else if (stall_cnt_q == STALL_LAST) begin
               state_d     = S_IDLE;
               rr_last_d   = grant_q;
               byte_cnt_d  = '0;
               stall_cnt_d = '0;
               abort_d     = 1'b1;
            end else begin
               stall_cnt_d = stall_cnt_q + SW'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of evaluation order.
      if (!Resetn) begin
         state_q     <= S_IDLE;
         grant_q     <= '0;
         rr_last_q   <= RR_RESET;
         byte_cnt_q  <= '0;
         stall_cnt_q <= '0;
         trunc_q     <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         rr_last_q   <= rr_last_d;
         byte_cnt_q  <= byte_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         trunc_q     <= trunc_d;
         abort_q     <= abort_d;
      end
   end

   assign grant_id    = grant_q;
   assign busy        = (state_q != S_IDLE);
   assign trunc_pulse = trunc_q;
   assign abort_pulse = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter (4 requesters,
// header on, 4-byte length cap, 8-cycle timeout). Stimulus pushes bytes into
// per-requester source queues and the expected FIFO byte stream into a
// scoreboard; a negedge monitor pops and compares every FIFO write.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int GW      = 2;

   logic                 Clk = 1'b0;
   logic                 Resetn;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           uart_tx_data;
   logic                 uart_wr_en;
   logic                 uart_full;
   logic [GW-1:0]        grant_id;
   logic                 busy;
   logic                 trunc_pulse;
   logic                 abort_pulse;

   int checks = 0;
   int errors = 0;

   // Source queues hold {last, data}; the scoreboard holds expected FIFO bytes.
   logic [8:0]         src_q [NUM_REQ][$];
   logic [7:0]         exp_q [$];
   logic [NUM_REQ-1:0] acc_q;
   logic [7:0]         exp_byte;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ),
      .HEADER_EN(1'b1),
      .MAX_PKT_LEN(4),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .Clk(Clk),
      .Resetn(Resetn),
      .req_data(req_data),
      .req_valid(req_valid),
      .req_last(req_last),
      .req_ready(req_ready),
      .uart_tx_data(uart_tx_data),
      .uart_wr_en(uart_wr_en),
      .uart_full(uart_full),
      .grant_id(grant_id),
      .busy(busy),
      .trunc_pulse(trunc_pulse),
      .abort_pulse(abort_pulse)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present the head of each source queue to the DUT.
   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (src_q[i].size() > 0) begin
            req_valid[i]       = 1'b1;
            req_last[i]        = src_q[i][0][8];
            req_data[8*i +: 8] = src_q[i][0][7:0];
         end else begin
            req_valid[i]       = 1'b0;
            req_last[i]        = 1'b0;
            req_data[8*i +: 8] = 8'h00;
         end
      end
   endtask

   // Advance one clock: pop bytes accepted at this edge, then re-drive.
   task automatic tick();
      @(posedge Clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (acc_q[i] && src_q[i].size() > 0) begin
            void'(src_q[i].pop_front());
         end
      end
      drive();
   endtask

   task automatic sample();
      @(negedge Clk);
      #1;
   endtask

   task automatic push_src(input int r, input logic [7:0] d, input logic l);
      src_q[r].push_back({l, d});
   endtask

   task automatic clear_src();
      for (int i = 0; i < NUM_REQ; i++) begin
         src_q[i].delete();
      end
   endtask

   // Monitor: record handshakes and score every FIFO write.
   always @(negedge Clk) begin
      acc_q = req_valid & req_ready;
      if (uart_wr_en === 1'b1) begin
         check("wr_while_full", 32'(uart_full), 32'h0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %02h expected no write", uart_tx_data);
         end else begin
            exp_byte = exp_q.pop_front();
            check("fifo_byte", 32'(uart_tx_data), 32'(exp_byte));
         end
      end
   end

   initial begin
      uart_full = 1'b0;
      Resetn    = 1'b0;
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      acc_q     = '0;
      drive();
      tick();
      tick();

      // Reset state
      sample();
      check("rst_busy",  32'(busy),         32'h0);
      check("rst_wr_en", 32'(uart_wr_en),   32'h0);
      check("rst_ready", 32'(req_ready),    32'h0);
      check("rst_data",  32'(uart_tx_data), 32'h0);
      check("rst_grant", 32'(grant_id),     32'h0);
      check("rst_trunc", 32'(trunc_pulse),  32'h0);
      check("rst_abort", 32'(abort_pulse),  32'h0);
      tick();
      Resetn = 1'b1;

      // Single requester 2: A2,11,22,33 back to back after one arbitration cycle
      push_src(2, 8'h11, 1'b0);
      push_src(2, 8'h22, 1'b0);
      push_src(2, 8'h33, 1'b1);
      exp_q.push_back(8'hA2);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      drive();
      for (int k = 0; k < 6; k++) begin
         sample();
         check($sformatf("t1_busy_c%0d", k),  32'(busy),       32'((k >= 1 && k <= 4) ? 1 : 0));
         check($sformatf("t1_wr_en_c%0d", k), 32'(uart_wr_en), 32'((k >= 1 && k <= 4) ? 1 : 0));
         tick();
      end
      check("t1_drain", 32'(exp_q.size()), 32'h0);

      // Round robin after reset: 0,1,3 then 0 again
      Resetn = 1'b0;
      tick();
      Resetn = 1'b1;
      push_src(0, 8'h50, 1'b1);
      push_src(0, 8'h60, 1'b1);
      push_src(1, 8'h51, 1'b1);
      push_src(3, 8'h53, 1'b1);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'h50);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'h51);
      exp_q.push_back(8'hA3);
      exp_q.push_back(8'h53);
      exp_q.push_back(8'hA0);
      exp_q.push_back(8'h60);
      drive();
      for (int k = 0; k < 14; k++) begin
         sample();
         if (k == 3) check("t2_gap_busy", 32'(busy), 32'h0);
         if (k == 4) check("t2_grant1", 32'(grant_id), 32'h1);
         if (k == 7) check("t2_grant3", 32'(grant_id), 32'h3);
         tick();
      end
      check("t2_drain", 32'(exp_q.size()), 32'h0);

      // FIFO full for 5 cycles mid-packet on requester 1
      push_src(1, 8'h71, 1'b0);
      push_src(1, 8'h72, 1'b0);
      push_src(1, 8'h73, 1'b1);
      exp_q.push_back(8'hA1);
      exp_q.push_back(8'h71);
      exp_q.push_back(8'h72);
      exp_q.push_back(8'h73);
      drive();
      for (int k = 0; k < 12; k++) begin
         uart_full = (k >= 3 && k <= 7);
         sample();
         if (k >= 3 && k <= 7) begin
            check($sformatf("t3_wr_en_full_c%0d", k), 32'(uart_wr_en), 32'h0);
            check($sformatf("t3_ready_full_c%0d", k), 32'(req_ready),  32'h0);
         end
         if (k == 8) begin
            check("t3_wr_en_resume", 32'(uart_wr_en), 32'h1);
            check("t3_ready_resume", 32'(req_ready),  32'h2);
         end
         check($sformatf("t3_abort_c%0d", k), 32'(abort_pulse), 32'h0);
         tick();
      end
      uart_full = 1'b0;
      check("t3_drain", 32'(exp_q.size()), 32'h0);

      // Length cap at 4 on requester 3, tail repacketised, then timeout abort
      for (int k = 0; k < 26; k++) begin
         if (k == 0) begin
            push_src(3, 8'h81, 1'b0);
            push_src(3, 8'h82, 1'b0);
            push_src(3, 8'h83, 1'b0);
            push_src(3, 8'h84, 1'b0);
            push_src(3, 8'h85, 1'b0);
            push_src(3, 8'h86, 1'b0);
            push_src(0, 8'h90, 1'b1);
            exp_q.push_back(8'hA3);
            exp_q.push_back(8'h81);
            exp_q.push_back(8'h82);
            exp_q.push_back(8'h83);
            exp_q.push_back(8'h84);
            exp_q.push_back(8'hA0);
            exp_q.push_back(8'h90);
            exp_q.push_back(8'hA3);
            exp_q.push_back(8'h85);
            exp_q.push_back(8'h86);
            drive();
         end
         if (k == 15) begin
            push_src(1, 8'hA5, 1'b1);
            exp_q.push_back(8'hA1);
            exp_q.push_back(8'hA5);
            drive();
         end
         sample();
         check($sformatf("t4_trunc_c%0d", k), 32'(trunc_pulse), 32'((k == 6) ? 1 : 0));
         check($sformatf("t4_abort_c%0d", k), 32'(abort_pulse), 32'((k == 21) ? 1 : 0));
         if (k == 7)  check("t4_grant_after_trunc", 32'(grant_id), 32'h0);
         if (k == 22) check("t4_grant_after_abort", 32'(grant_id), 32'h1);
         tick();
      end
      check("t4_drain", 32'(exp_q.size()), 32'h0);

      // Reset pulse mid-payload on requester 2, then requester 0 wins first
      push_src(2, 8'hB1, 1'b0);
      push_src(2, 8'hB2, 1'b0);
      push_src(2, 8'hB3, 1'b0);
      push_src(2, 8'hB4, 1'b1);
      exp_q.push_back(8'hA2);
      exp_q.push_back(8'hB1);
      exp_q.push_back(8'hB2);
      drive();
      for (int k = 0; k < 13; k++) begin
         if (k == 3) Resetn = 1'b0;
         if (k == 4) begin
            Resetn = 1'b1;
            clear_src();
            drive();
         end
         if (k == 5) begin
            push_src(3, 8'hC3, 1'b1);
            push_src(0, 8'hC0, 1'b1);
            exp_q.push_back(8'hA0);
            exp_q.push_back(8'hC0);
            exp_q.push_back(8'hA3);
            exp_q.push_back(8'hC3);
            drive();
         end
         sample();
         if (k == 4) begin
            check("t6_busy",  32'(busy),         32'h0);
            check("t6_wr_en", 32'(uart_wr_en),   32'h0);
            check("t6_ready", 32'(req_ready),    32'h0);
            check("t6_data",  32'(uart_tx_data), 32'h0);
            check("t6_grant", 32'(grant_id),     32'h0);
         end
         if (k == 6) check("t6_first_grant",  32'(grant_id), 32'h0);
         if (k == 9) check("t6_second_grant", 32'(grant_id), 32'h3);
         tick();
      end
      check("final_drain", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
